div_seq_param: RTL

Parametrised sequential integer divider: the next generation of the team's 4-bit restoring divider. It generalises operand width and adds a run-time signed/unsigned mode, a selectable restoring or non-restoring core, defined divide-by-zero and signed-overflow results, and a busy indicator. It sits in the arithmetic datapath as a multi-cycle unit behind a start/valid handshake.

---
 rtl/div_pkg.sv | 34 +++
 rtl/div_step.sv | 43 ++++
 rtl/div_seq_param.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider family.
// Holds the controller state encoding, the core-algorithm selectors and
// the divide-by-zero quotient helper used by the top level.
package div_pkg;

  // Controller states, in the order an operation visits them.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } div_state_e;

  // Core algorithm selectors for the ALGO parameter.
  localparam int ALGO_RESTORING    = 0;
  localparam int ALGO_NONRESTORING = 1;

  // Widest operand the helper below can describe.
  localparam int DIV_MAX_W = 64;

  // Quotient reported for a zero divisor: 2^w-1 unsigned, -1 signed.
  // Both are all ones in the low w bits; callers truncate to their width.
  function automatic logic [DIV_MAX_W-1:0] dbz_quot(input logic smode, input int w);
    logic [DIV_MAX_W-1:0] ones;
    if (w >= DIV_MAX_W) begin
      ones = '1;
    end else begin
      ones = (DIV_MAX_W'(1) << w) - DIV_MAX_W'(1);
    end
    return smode ? '1 : ones;
  endfunction

endpackage

// File: rtl/div_step.sv
// One quotient-bit iteration of the divider core, purely combinational.
// Shifts the next dividend bit into the partial remainder, trial-subtracts
// (or adds back, non-restoring) the divisor and shifts the quotient bit in.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ALGO  = ALGO_RESTORING
) (
  input  logic [WIDTH:0]   pr_i,   // partial remainder, two's complement
  input  logic [WIDTH-1:0] dvd_i,  // dividend bits still to consume, MSB first
  input  logic [WIDTH-1:0] dvs_i,  // divisor magnitude
  output logic [WIDTH:0]   pr_o,
  output logic [WIDTH-1:0] dvd_o,  // dividend shifted left, quotient bit in LSB
  output logic             q_o
);

  // One extra bit above the partial remainder so the shifted value and the
  // trial result never overflow before the sign is inspected.
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] dvs_ext;
  logic [WIDTH+1:0] trial;

  assign shifted = {pr_i, dvd_i[WIDTH-1]};
  assign dvs_ext = {2'b00, dvs_i};

  generate
    if (ALGO == ALGO_NONRESTORING) begin : g_nonrest
      // A negative remainder is repaired by adding on the next step instead
      // of being restored now; the final correction happens in FIX.
      assign trial = pr_i[WIDTH] ? (shifted + dvs_ext) : (shifted - dvs_ext);
      assign pr_o  = trial[WIDTH:0];
    end else begin : g_rest
      // Keep the shifted remainder whenever the trial subtraction borrows.
      assign trial = shifted - dvs_ext;
      assign pr_o  = trial[WIDTH+1] ? shifted[WIDTH:0] : trial[WIDTH:0];
    end
  endgenerate

  assign q_o   = ~trial[WIDTH+1];
  assign dvd_o = {dvd_i[WIDTH-2:0], q_o};

endmodule

// File: rtl/div_seq_param.sv
// Parametrised sequential signed/unsigned integer divider, one bit per cycle.
// Latency: valid WIDTH+2 edges after the start edge, 1 edge for a zero divisor.
// start is only honoured in IDLE; requests while busy are dropped.
module div_seq_param
  import div_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ALGO  = ALGO_RESTORING
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             valid,
  output logic             busy,
  output logic             dbz,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  div_state_e       state_q;
  logic [WIDTH-1:0] x_q, y_q;
  logic             smode_q;
  logic             qneg_q, rneg_q;
  logic [WIDTH:0]   pr_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [CW-1:0]    cnt_q;
  logic             valid_q, busy_q, dbz_q;
  logic [WIDTH-1:0] quot_q, rem_q;

  logic             x_neg, y_neg;
  logic [WIDTH-1:0] xmag_d, ymag_d;
  logic [WIDTH:0]   pr_d;
  logic [WIDTH-1:0] dvd_d;
  logic             qbit_d;
  logic [WIDTH-1:0] rem_mag;
  logic [WIDTH-1:0] quot_d, rem_d;

  // Operand signs and magnitudes from the latched operands. Negating the
  // most negative value yields 2^(WIDTH-1), which is exact as an unsigned
  // magnitude, so the overflow case needs no special handling.
  always_comb begin
    x_neg  = smode_q & x_q[WIDTH-1];
    y_neg  = smode_q & y_q[WIDTH-1];
    xmag_d = x_neg ? (~x_q + 1'b1) : x_q;
    ymag_d = y_neg ? (~y_q + 1'b1) : y_q;
  end

  div_step #(
    .WIDTH (WIDTH),
    .ALGO  (ALGO)
  ) u_step (
    .pr_i  (pr_q),
    .dvd_i (dvd_q),
    .dvs_i (dvs_q),
    .pr_o  (pr_d),
    .dvd_o (dvd_d),
    .q_o   (qbit_d)
  );

  // Final remainder correction and sign application for the FIX state. The
  // true remainder lies in [0, divisor), so WIDTH-bit modular arithmetic on
  // the corrected value is exact.
  always_comb begin
    rem_mag = pr_q[WIDTH-1:0];
    if ((ALGO == ALGO_NONRESTORING) && pr_q[WIDTH]) begin
      rem_mag = pr_q[WIDTH-1:0] + dvs_q;
    end
    quot_d = qneg_q ? (~dvd_q + 1'b1) : dvd_q;
    rem_d  = rneg_q ? (~rem_mag + 1'b1) : rem_mag;
  end

  // Controller with all outputs registered; reset aborts any operation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      smode_q <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      pr_q    <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      dbz_q   <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            x_q     <= X;
            y_q     <= Y;
            smode_q <= signed_mode;
            busy_q  <= 1'b1;
            state_q <= PREP;
          end
        end
        PREP: begin
          qneg_q <= x_neg ^ y_neg;
          rneg_q <= x_neg;
          if (y_q == '0) begin
            // Zero divisor: report immediately, remainder is the raw dividend.
            quot_q  <= WIDTH'(dbz_quot(smode_q, WIDTH));
            rem_q   <= x_q;
            dbz_q   <= 1'b1;
            valid_q <= 1'b1;
            state_q <= DONE;
          end else begin
            pr_q    <= '0;
            dvd_q   <= xmag_d;
            dvs_q   <= ymag_d;
            cnt_q   <= '0;
            state_q <= ITER;
          end
        end
        ITER: begin
          pr_q  <= pr_d;
          dvd_q <= dvd_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_ITER) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          quot_q  <= quot_d;
          rem_q   <= rem_d;
          dbz_q   <= 1'b0;
          valid_q <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // qbit_d is already folded into dvd_d; keep it observable for debug taps.
  logic unused_qbit;
  assign unused_qbit = qbit_d;

  assign valid = valid_q;
  assign busy  = busy_q;
  assign dbz   = dbz_q;
  assign quot  = quot_q;
  assign rem   = rem_q;

endmodule
